// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, fault causes, the request record and the fault check.
package dmem_responder_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        FaultNone       = 2'd0,
        FaultMisaligned = 2'd1,
        FaultRange      = 2'd2
    } dmem_fault_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  wdata;
        logic [STRB_W-1:0] wstrb;
    } dmem_req_t;

    function automatic dmem_fault_e fault_cause(input logic [ADDR_W-1:0] addr,
                                                input int unsigned      depth);
        if (addr[1:0] != 2'b00) begin
            return FaultMisaligned;
        end
        if ({2'b00, addr[ADDR_W-1:2]} >= 32'(depth)) begin
            return FaultRange;
        end
        return FaultNone;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-lane RAM with synchronous read.
// A read in the same cycle as a write to the same word returns the old contents.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [3:0]                     we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] widx,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[widx];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word access, configurable latency,
// response channel with valid/ready backpressure and access-fault reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        lat_q;
    dmem_req_t        cur;
    dmem_fault_e      cur_fault;
    dmem_fault_e      lat_fault;
    logic             accept;
    logic             commit;
    logic [3:0]       arr_we;
    logic [31:0]      arr_rdata;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    // With zero latency the commit edge is the accept edge, so the live request
    // must feed the RAM directly; afterwards the latched copy is authoritative.
    always_comb begin
        cur = lat_q;
        if (state_q == StIdle) begin
            cur.we    = req_we;
            cur.addr  = req_addr;
            cur.wdata = req_wdata;
            cur.wstrb = req_wstrb;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                lat_q <= cur;
            end
        end
    end

    assign cur_fault = fault_cause(cur.addr, DEPTH_WORDS);
    assign lat_fault = fault_cause(lat_q.addr, DEPTH_WORDS);

    // Reset gating keeps an uncommitted store out of the RAM.
    assign arr_we = (commit && cur.we && (cur_fault == FaultNone) && !rst) ? cur.wstrb : 4'b0000;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .widx (cur.addr[2 +: IDX_W]),
        .wdata(cur.wdata),
        .rdata(arr_rdata)
    );

    // The RAM read register is loaded at the commit edge and the index stays
    // fixed while in RESP, so load data holds without a second register.
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = rsp_valid && (lat_fault != FaultNone);
    assign rsp_rdata = (rsp_valid && !lat_q.we && (lat_fault == FaultNone)) ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array model,
// covering a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_responder;

    localparam int DEPTH_A = 1024;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_we = 1'b0, a_rsp_ready = 1'b0;
    logic [31:0] a_req_addr = '0, a_req_wdata = '0;
    logic [3:0]  a_req_wstrb = '0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_wstrb = '0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_wstrb(a_req_wstrb), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_wstrb(b_req_wstrb), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] model [DEPTH_A];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on instance A; starts and ends at a negedge with A idle.
    task automatic a_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold, output logic [31:0] got_rd);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        int          idx;
        exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(DEPTH_A));
        idx     = int'(addr >> 2);
        exp_rd  = (we || exp_err) ? 32'h0 : model[idx];
        n = 0;
        while (!a_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_idle", {31'b0, a_req_ready}, 32'h1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_wstrb = strb;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        a_req_we    = 1'($urandom);
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        a_req_wstrb = 4'($urandom);
        if (we && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_rsp_valid && n < 40);
        check_eq("latency", 32'(n), 32'(LAT_A + 1));
        check_eq("rdata", a_rsp_rdata, exp_rd);
        check_eq("err", {31'b0, a_rsp_err}, {31'b0, exp_err});
        got_rd = a_rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {31'b0, a_rsp_valid}, 32'h1);
            check_eq("hold_rdata", a_rsp_rdata, exp_rd);
            check_eq("hold_err", {31'b0, a_rsp_err}, {31'b0, exp_err});
            check_eq("hold_ready", {31'b0, a_req_ready}, 32'h0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("after_valid", {31'b0, a_rsp_valid}, 32'h0);
        check_eq("after_ready", {31'b0, a_req_ready}, 32'h1);
    endtask

    // Single transaction on the zero-latency instance B.
    task automatic b_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        b_req_valid = 1'b1;
        b_req_we    = we;
        b_req_addr  = addr;
        b_req_wdata = wdata;
        b_req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        check_eq("b_valid_t1", {31'b0, b_rsp_valid}, 32'h1);
        check_eq("b_rdata", b_rsp_rdata, exp_rd);
        check_eq("b_err", {31'b0, b_rsp_err}, {31'b0, exp_err});
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("b_idle", {31'b0, b_req_ready}, 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        int          r;
        int          accepts;

        repeat (3) @(negedge clk);
        check_eq("ready_in_reset", {31'b0, a_req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", {31'b0, a_rsp_valid}, 32'h0);
        check_eq("rst_err", {31'b0, a_rsp_err}, 32'h0);
        check_eq("rst_rdata", a_rsp_rdata, 32'h0);
        check_eq("rst_ready", {31'b0, a_req_ready}, 32'h1);

        for (int w = 0; w < 16; w++) a_xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd);
        a_xact(1'b1, 32'((DEPTH_A - 1) * 4), $urandom, 4'hF, 0, rd);

        a_xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        a_xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check_eq("store_load", rd, 32'hDEADBEEF);

        a_xact(1'b1, 32'h14, 32'h11223344, 4'hF, 0, rd);
        a_xact(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 0, rd);
        a_xact(1'b0, 32'h14, 32'h0, 4'h0, 0, rd);
        check_eq("partial_strobe", rd, 32'h11BB33DD);

        a_xact(1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

        a_xact(1'b0, 32'h13, 32'h0, 4'h0, 1, rd);
        a_xact(1'b1, 32'(DEPTH_A * 4), 32'h55AA55AA, 4'hF, 0, rd);
        a_xact(1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
        a_xact(1'b1, 32'h18, 32'h12345678, 4'h0, 0, rd);
        a_xact(1'b0, 32'h18, 32'h0, 4'h0, 0, rd);

        // Reset while a store to 0x20 sits in WAIT.
        a_req_valid = 1'b1;
        a_req_we    = 1'b1;
        a_req_addr  = 32'h20;
        a_req_wdata = 32'hFEEDFACE;
        a_req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midop_ready_rst", {31'b0, a_req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midop_valid", {31'b0, a_rsp_valid}, 32'h0);
        check_eq("midop_ready", {31'b0, a_req_ready}, 32'h1);
        a_xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 19);
            if (r < 16)       addr = 32'(r * 4);
            else if (r == 16) addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 17) addr = 32'((DEPTH_A + $urandom_range(0, 4000)) * 4);
            else if (r == 18) addr = 32'((DEPTH_A - 1) * 4);
            else              addr = 32'hFFFF_FFFC;
            a_xact(1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
        end

        b_xact(1'b1, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0);
        b_xact(1'b0, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0);
        b_xact(1'b1, 32'(DEPTH_B * 4), 32'h1, 32'h0, 1'b1);
        b_xact(1'b0, 32'h9, 32'h0, 32'h0, 1'b1);

        // Continuous requests with rsp_ready high: accepted every second cycle.
        b_req_valid = 1'b1;
        b_req_we    = 1'b0;
        b_req_addr  = 32'h8;
        b_rsp_ready = 1'b1;
        accepts     = 0;
        for (int c = 0; c < 12; c++) begin
            check_eq("b2b_ready", {31'b0, b_req_ready}, 32'((c % 2) == 0));
            check_eq("b2b_valid", {31'b0, b_rsp_valid}, 32'((c % 2) == 1));
            if (b_rsp_valid) check_eq("b2b_rdata", b_rsp_rdata, 32'hCAFEF00D);
            if (b_req_ready) accepts++;
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        b_rsp_ready = 1'b0;
        check_eq("b2b_accepts", 32'(accepts), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
